game_round_scheduler: RTL and testbench

//  Sequences one Morse game session for the game controller (easy/hard).

---
 rtl/game_round_scheduler.sv | 157 +++++++++++++++
 tb/tb_game_round_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_round_scheduler.sv
// Morse game session sequencer: start/load strobes, per-round seconds countdown,
// timeout on expiry and game_over after the last round. All outputs are registered.
module game_round_scheduler #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int ROUND_SECS = 10,
    parameter int NUM_ROUNDS = 10,
    parameter int LOAD_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LoggedIn,
    input  logic       start_req,
    input  logic       enable,
    input  logic       answered,
    input  logic       logout,
    output logic       game_start,
    output logic       load,
    output logic       timeout,
    output logic [3:0] round_num,
    output logic [5:0] secs_left,
    output logic       game_over,
    output logic       busy
);

    localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DLY_LAST   = DW'(LOAD_DELAY - 1);
    localparam logic [5:0]    SECS_INIT  = 6'(ROUND_SECS);
    localparam logic [3:0]    ROUND_LAST = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DELAY = 3'd2,
        S_LOAD  = 3'd3,
        S_RUN   = 3'd4,
        S_TMO   = 3'd5,
        S_NEXT  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    round_q, round_d;
    logic [5:0]    secs_q, secs_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          game_start_q, load_q, timeout_q, game_over_q, busy_q;

    // Next-state and datapath update; logout or lost login overrides every state.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        secs_d  = secs_q;
        tick_d  = tick_q;
        dcnt_d  = dcnt_q;
        if (logout || !LoggedIn) begin
            state_d = S_IDLE;
            round_d = 4'd0;
            secs_d  = 6'd0;
            tick_d  = TW'(0);
            dcnt_d  = DW'(0);
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_req) begin
                        state_d = S_START;
                        round_d = 4'd1;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_START: begin
                    state_d = S_DELAY;
                    dcnt_d  = DW'(0);
                end
                S_DELAY: begin
                    if (dcnt_q == DLY_LAST) begin
                        state_d = S_LOAD;
                        secs_d  = SECS_INIT;
                        tick_d  = TW'(0);
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    // An answer beats a same-cycle expiry and freezes the countdown.
                    if (answered) begin
                        state_d = S_NEXT;
                    end else if (enable) begin
                        if (tick_q == TICK_LAST) begin
                            tick_d = TW'(0);
                            secs_d = secs_q - 6'd1;
                            if (secs_q == 6'd1) begin
                                state_d = S_TMO;
                            end else begin
                                state_d = S_RUN;
                            end
                        end else begin
                            tick_d = tick_q + TW'(1);
                        end
                    end else begin
                        tick_d = tick_q;
                    end
                end
                S_TMO: state_d = S_NEXT;
                S_NEXT: begin
                    if (round_q == ROUND_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DELAY;
                        round_d = round_q + 4'd1;
                        dcnt_d  = DW'(0);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters and Moore outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            round_q      <= 4'd0;
            secs_q       <= 6'd0;
            tick_q       <= TW'(0);
            dcnt_q       <= DW'(0);
            game_start_q <= 1'b0;
            load_q       <= 1'b0;
            timeout_q    <= 1'b0;
            game_over_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            secs_q       <= secs_d;
            tick_q       <= tick_d;
            dcnt_q       <= dcnt_d;
            game_start_q <= (state_d == S_START);
            load_q       <= (state_d == S_LOAD);
            timeout_q    <= (state_d == S_TMO);
            game_over_q  <= (state_d == S_DONE);
            busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE);
        end
    end

    assign game_start = game_start_q;
    assign load       = load_q;
    assign timeout    = timeout_q;
    assign round_num  = round_q;
    assign secs_left  = secs_q;
    assign game_over  = game_over_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Scoreboard bench for game_round_scheduler: a phase/arithmetic model predicts every
// change of the output vector; a monitor pops and compares on each observed change.
module tb_game_round_scheduler;

    localparam int CLK_HZ     = 4;
    localparam int ROUND_SECS = 3;
    localparam int NUM_ROUNDS = 2;
    localparam int LOAD_DELAY = 2;

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_DELAY = 2;
    localparam int P_LOAD  = 3;
    localparam int P_RUN   = 4;
    localparam int P_TMO   = 5;
    localparam int P_NEXT  = 6;
    localparam int P_DONE  = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       LoggedIn = 1'b0;
    logic       start_req = 1'b0;
    logic       enable = 1'b0;
    logic       answered = 1'b0;
    logic       logout = 1'b0;
    logic       game_start, load, timeout, game_over, busy;
    logic [3:0] round_num;
    logic [5:0] secs_left;

    game_round_scheduler #(
        .CLK_HZ    (CLK_HZ),
        .ROUND_SECS(ROUND_SECS),
        .NUM_ROUNDS(NUM_ROUNDS),
        .LOAD_DELAY(LOAD_DELAY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .LoggedIn  (LoggedIn),
        .start_req (start_req),
        .enable    (enable),
        .answered  (answered),
        .logout    (logout),
        .game_start(game_start),
        .load      (load),
        .timeout   (timeout),
        .round_num (round_num),
        .secs_left (secs_left),
        .game_over (game_over),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int          cyc;
        logic [14:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: phase, round, seconds from enabled-cycle count.
    int          m_ph = P_IDLE;
    int          m_rnd = 0;
    int          m_secs = 0;
    int          m_en_cnt = 0;
    int          m_dly = 0;
    logic [14:0] m_prev = 15'd0;

    function automatic logic [14:0] pack(input logic gs, input logic ld, input logic to,
                                         input logic [3:0] r, input logic [5:0] s,
                                         input logic go, input logic bz);
        return {gs, ld, to, r, s, go, bz};
    endfunction

    function automatic logic [14:0] dut_vec();
        return pack(game_start, load, timeout, round_num, secs_left, game_over, busy);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_step(input logic li, input logic sr, input logic en,
                              input logic ans, input logic lo);
        logic [14:0] v;
        exp_t        e;
        if (!li || lo) begin
            m_ph = P_IDLE; m_rnd = 0; m_secs = 0; m_en_cnt = 0;
        end else begin
            case (m_ph)
                P_IDLE, P_DONE: if (sr) begin m_ph = P_START; m_rnd = 1; end
                P_START: begin m_ph = P_DELAY; m_dly = 0; end
                P_DELAY: begin
                    m_dly++;
                    if (m_dly == LOAD_DELAY) begin
                        m_ph = P_LOAD; m_secs = ROUND_SECS; m_en_cnt = 0;
                    end
                end
                P_LOAD: m_ph = P_RUN;
                P_RUN: begin
                    if (ans) m_ph = P_NEXT;
                    else if (en) begin
                        m_en_cnt++;
                        m_secs = ROUND_SECS - m_en_cnt / CLK_HZ;
                        if (m_secs == 0) m_ph = P_TMO;
                    end
                end
                P_TMO: m_ph = P_NEXT;
                P_NEXT: begin
                    if (m_rnd == NUM_ROUNDS) m_ph = P_DONE;
                    else begin m_rnd++; m_ph = P_DELAY; m_dly = 0; end
                end
                default: m_ph = P_IDLE;
            endcase
        end
        v = pack(m_ph == P_START, m_ph == P_LOAD, m_ph == P_TMO, 4'(m_rnd), 6'(m_secs),
                 m_ph == P_DONE, (m_ph != P_IDLE) && (m_ph != P_DONE));
        if (v != m_prev) begin
            e.cyc = cyc_cnt + 1;
            e.v   = v;
            exp_q.push_back(e);
        end
        m_prev = v;
    endtask

    task automatic step(input logic li, input logic sr, input logic en,
                        input logic ans, input logic lo);
        @(negedge clk);
        LoggedIn = li; start_req = sr; enable = en; answered = ans; logout = lo;
        model_step(li, sr, en, ans, lo);
    endtask

    // Monitor: on every change of the DUT output vector, pop and compare.
    bit          mon_en = 1'b0;
    logic [14:0] mon_prev = 15'd0;
    logic [14:0] mon_cur;
    exp_t        mon_e;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            mon_cur = dut_vec();
            if (mon_cur != mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d actual=%h required=no change",
                             cyc_cnt, mon_cur);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc_cnt || mon_e.v != mon_cur) begin
                        errors++;
                        $display("FAIL scoreboard actual=%h@cyc%0d required=%h@cyc%0d",
                                 mon_cur, cyc_cnt, mon_e.v, mon_e.cyc);
                    end
                end
                mon_prev = mon_cur;
            end
        end
    end

    bit   froze;
    logic li_r, sr_r, en_r, ans_r, lo_r;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // start_req while logged out is ignored
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("no_start_logged_out", 32'(game_start), 32'd0);
        chk("idle_not_busy", 32'(busy), 32'd0);

        // Full game without answers
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("game_start_strobe", 32'(game_start), 32'd1);
        chk("round_after_start", 32'(round_num), 32'd1);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("load_latency", 32'(load), 32'd1);
        chk("secs_at_load", 32'(secs_left), 32'(ROUND_SECS));
        for (int i = 0; i < 60 && m_ph != P_DONE; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("done_game_over", 32'(game_over), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_round", 32'(round_num), 32'(NUM_ROUNDS));

        // Restart from DONE; answer on the final wrap of round 1
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            ans_r = (m_ph == P_RUN) && (m_en_cnt == ROUND_SECS * CLK_HZ - 1);
            step(1'b1, 1'b0, 1'b1, ans_r, 1'b0);
            if (ans_r) break;
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("answer_beats_expiry_tmo", 32'(timeout), 32'd0);
        chk("answer_freezes_secs", 32'(secs_left), 32'd1);
        for (int i = 0; i < 10 && m_ph != P_LOAD; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reload_after_answer", 32'(load), 32'd1);
        chk("round_two", 32'(round_num), 32'd2);

        // Round 2: freeze the countdown for 10 cycles mid-round
        froze = 1'b0;
        for (int i = 0; i < 80 && m_ph != P_DONE; i++) begin
            if (!froze && m_ph == P_RUN && m_en_cnt == 5) begin
                repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                chk("freeze_secs", 32'(secs_left), 32'(ROUND_SECS - 5 / CLK_HZ));
                froze = 1'b1;
            end else begin
                step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("done_after_freeze", 32'(game_over), 32'd1);

        // Logout during DELAY
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && m_ph != P_DELAY; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("logout_round", 32'(round_num), 32'd0);
        chk("logout_busy", 32'(busy), 32'd0);
        chk("logout_no_load", 32'(load), 32'd0);
        repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !(m_ph == P_RUN && m_en_cnt > 3); i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(dut_vec()), 32'd0);
        repeat (2) @(posedge clk);
        exp_q.delete();
        m_ph = P_IDLE; m_rnd = 0; m_secs = 0; m_en_cnt = 0; m_prev = 15'd0;
        mon_prev = 15'd0;
        @(negedge clk);
        start_req = 1'b0;
        rst = 1'b1;
        mon_en = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_after_reset", 32'(game_start), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            li_r  = ($urandom_range(0, 199) != 0);
            sr_r  = ($urandom_range(0, 99) < 6);
            en_r  = ($urandom_range(0, 99) < 80);
            ans_r = ($urandom_range(0, 99) < 4);
            lo_r  = ($urandom_range(0, 299) == 0);
            step(li_r, sr_r, en_r, ans_r, lo_r);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_outputs", 32'(dut_vec()), 32'(m_prev));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
